// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the execute-stage ALU blocks.
//   - ALU operation codes handled by the iterative mul/div sequencer
//     (also decoded by alu_control).
//   - FSM state type of the mul/div sequencer.
//   - Mode select of the single-iteration mul/div datapath.
package mips_pkg;

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } muldiv_mode_t;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: request/response bundle between the execute stage
// (master) and the mul/div sequencer (slave).
//   start, Operation, a, b, flush : requester -> sequencer
//   busy, stall, done, hi, lo     : sequencer -> requester
//   dbg_state                     : sequencer FSM state, observation only
//
// Handshake: start is a strobe sampled at every rising edge. A request is
// accepted at the edge where the sequencer is IDLE, start is high, Operation
// is OP_MUL or OP_DIV and flush is low; stall is high combinationally in that
// cycle so the requester holds the instruction, and stays high until the
// result is returned. done is a one-cycle pulse and hi/lo are valid with it
// (and hold afterwards). start in any other state is dropped, never queued.
interface alu_muldiv_seq_if #(parameter int WIDTH = 32) ();
    import mips_pkg::*;

    logic             start;
    logic [3:0]       Operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    muldiv_state_t    dbg_state;

    modport master (
        output start, Operation, a, b, flush,
        input  busy, stall, done, hi, lo, dbg_state
    );

    modport slave (
        input  start, Operation, a, b, flush,
        output busy, stall, done, hi, lo, dbg_state
    );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the unsigned shift-add
// multiply or restoring divide.
//   mode     : MODE_MUL or MODE_DIV
//   acc      : 2*WIDTH working register
//              MUL: {partial product high, remaining multiplier / product low}
//              DIV: {partial remainder, remaining dividend / quotient bits}
//   operand  : multiplicand (MUL) or divisor (DIV)
//   acc_next : working register after this iteration; for DIV the LSB is
//              left at 0 and the quotient bit is delivered on q_bit
//   q_bit    : quotient bit of this iteration (0 in MUL mode)
module muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  muldiv_mode_t       mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        addend   = acc[0] ? operand : {WIDTH{1'b0}};
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Partial remainder shifted left with the next dividend bit brought in.
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        diff     = shifted - {1'b0, operand};
        q_bit    = 1'b0;
        acc_next = acc;
        if (mode == MODE_MUL) begin
            // Carry out of the add becomes the new top bit after the shift.
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            // Trial subtraction succeeded when the borrow (sign) bit is clear.
            q_bit    = ~diff[WIDTH];
            acc_next = {(q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative sequencer for the ALU's mul (OP_MUL) and
// div (OP_DIV) operations, unsigned, one iteration per clock, WIDTH steps.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : alu_muldiv_seq_if.slave (request, flush, busy/stall/done, hi/lo)
// Divide by zero completes without iterating: lo = all ones, hi = a.
module alu_muldiv_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_muldiv_seq_if.slave  bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    muldiv_state_t      state, state_next;
    muldiv_mode_t       mode;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] acc_upd;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               q_bit;
    logic               req_ok, req_mul, req_div, req_dz;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (mode),
        .acc      (acc),
        .operand  (b_reg),
        .acc_next (step_acc),
        .q_bit    (q_bit)
    );

    // Quotient bit enters at the LSB slot the step leaves open.
    assign acc_upd = {step_acc[2*WIDTH-1:1], step_acc[0] | q_bit};
    assign mode    = (state == S_DIV) ? MODE_DIV : MODE_MUL;

    always_comb begin
        req_ok     = (state == S_IDLE) && bus.start && !bus.flush;
        req_mul    = req_ok && (bus.Operation == OP_MUL);
        req_div    = req_ok && (bus.Operation == OP_DIV) && (bus.b != '0);
        req_dz     = req_ok && (bus.Operation == OP_DIV) && (bus.b == '0);
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_mul)      state_next = S_MUL;
                else if (req_div) state_next = S_DIV;
                else if (req_dz)  state_next = S_DONE;
            end
            S_MUL, S_DIV: begin
                if (bus.flush)         state_next = S_IDLE;
                else if (cnt == LAST)  state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        bus.busy      = (state == S_MUL) || (state == S_DIV);
        // Combinational so the pipeline already holds in the request cycle.
        bus.stall     = bus.busy || req_mul || req_div || req_dz;
        bus.done      = (state == S_DONE);
        bus.hi        = hi_r;
        bus.lo        = lo_r;
        bus.dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            b_reg <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (req_mul || req_div) begin
                        acc   <= {{WIDTH{1'b0}}, bus.a};
                        b_reg <= bus.b;
                        cnt   <= '0;
                    end else if (req_dz) begin
                        hi_r <= bus.a;
                        lo_r <= '1;
                    end
                end
                S_MUL, S_DIV: begin
                    if (!bus.flush) begin
                        acc <= acc_upd;
                        if (cnt == LAST) begin
                            // Outputs only ever see the finished result.
                            hi_r <= acc_upd[2*WIDTH-1:WIDTH];
                            lo_r <= acc_upd[WIDTH-1:0];
                            cnt  <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;
    import mips_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [2*W-1:0] exp_q[$];

    alu_muldiv_seq_if #(.WIDTH(W)) bus ();

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2*W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] p;
        if (op == OP_MUL) begin
            p = 64'(a) * 64'(b);
            return p;
        end
        if (b == 0) return {a, {W{1'b1}}};
        return {a % b, a / b};
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        bus.start = 1'b0; bus.Operation = 4'b0000; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    endtask

    // Present a request for one cycle; returns just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.Operation = op; bus.a = a; bus.b = b;
        #1;
        check("stall_req", 64'(bus.stall), 64'(1));
        exp_q.push_back(model(op, a, b));
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Wait (bounded) for done; exp_edges counts edges from the current cycle.
    task automatic finish_op(input string tag, input int exp_edges);
        int edges = 0;
        int stalls = 0;
        logic [2*W-1:0] e;
        while (!bus.done && edges < 100) begin
            if (bus.stall) stalls++;
            @(posedge clk); #1;
            edges++;
        end
        if (!bus.done) begin
            check({tag, "_timeout"}, 64'(0), 64'(1));
            return;
        end
        check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_edges));
        check({tag, "_stall_done"}, 64'(bus.stall), 64'(0));
        check({tag, "_busy_done"}, 64'(bus.busy), 64'(0));
        if (exp_q.size() == 0) begin
            check({tag, "_expq_empty"}, 64'(0), 64'(1));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, 64'(bus.hi), 64'(e[2*W-1:W]));
            check({tag, "_lo"}, 64'(bus.lo), 64'(e[W-1:0]));
        end
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    task automatic count_dones(input string tag, input int cycles, input int exp_n);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.done) n++;
            @(posedge clk); #1;
        end
        check(tag, 64'(n), 64'(exp_n));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]   op;
        logic [W-1:0] ra, rb;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_stall", 64'(bus.stall), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        check("rst_state", 64'(bus.dbg_state), 64'(S_IDLE));
        rst_n = 1'b1;

        // Directed cases
        issue(OP_MUL, 6, 7);                       finish_op("mul_6x7", W);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish_op("mul_max", W);
        issue(OP_DIV, 100, 7);                     finish_op("div_100_7", W);
        issue(OP_DIV, 5, 0);                       finish_op("div_by_zero", 0);

        // Non-mul/div request is ignored
        @(posedge clk); #1;
        bus.start = 1'b1; bus.Operation = 4'b0000; bus.a = 9; bus.b = 9;
        #1;
        check("aluop_stall", 64'(bus.stall), 64'(0));
        @(posedge clk); #1;
        idle_inputs();
        check("aluop_state", 64'(bus.dbg_state), 64'(S_IDLE));
        check("aluop_busy", 64'(bus.busy), 64'(0));

        // flush and start together in IDLE: flush wins
        bus.start = 1'b1; bus.Operation = OP_MUL; bus.a = 3; bus.b = 3; bus.flush = 1'b1;
        #1;
        check("flush_start_stall", 64'(bus.stall), 64'(0));
        @(posedge clk); #1;
        idle_inputs();
        check("flush_start_busy", 64'(bus.busy), 64'(0));

        // Second start while busy is dropped
        issue(OP_MUL, 1234, 5678);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.Operation = OP_DIV; bus.a = 77; bus.b = 3;
        #1;
        check("busy_start_stall", 64'(bus.stall), 64'(1));
        @(posedge clk); #1;
        idle_inputs();
        finish_op("busy_start", W - 6);
        count_dones("busy_start_extra_done", 40, 0);

        // start in the DONE cycle is dropped
        issue(OP_DIV, 5, 0);
        check("done_cycle_done", 64'(bus.done), 64'(1));
        void'(exp_q.pop_front());
        bus.start = 1'b1; bus.Operation = OP_MUL; bus.a = 2; bus.b = 2;
        #1;
        check("done_cycle_stall", 64'(bus.stall), 64'(0));
        @(posedge clk); #1;
        idle_inputs();
        check("done_cycle_state", 64'(bus.dbg_state), 64'(S_IDLE));
        count_dones("done_cycle_no_done", 40, 0);

        // Flush at iteration 10 of 100/7 after 6x7
        issue(OP_MUL, 6, 7); finish_op("pre_flush_mul", W);
        issue(OP_DIV, 100, 7);
        void'(exp_q.pop_back());  // this request is aborted
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_state", 64'(bus.dbg_state), 64'(S_IDLE));
        check("flush_busy", 64'(bus.busy), 64'(0));
        check("flush_stall", 64'(bus.stall), 64'(0));
        count_dones("flush_no_done", 40, 0);
        check("flush_hi", 64'(bus.hi), 64'(0));
        check("flush_lo", 64'(bus.lo), 64'(42));

        // Reset at iteration 10
        issue(OP_DIV, 100, 7);
        void'(exp_q.pop_back());
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_stall", 64'(bus.stall), 64'(0));
        check("midrst_hi", 64'(bus.hi), 64'(0));
        check("midrst_lo", 64'(bus.lo), 64'(0));
        rst_n = 1'b1;
        issue(OP_MUL, 6, 7); finish_op("post_rst_mul", W);

        // Randomized requests
        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) ra = ra >> $urandom_range(0, 31);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(op, ra, rb);
            finish_op($sformatf("rand%0d", i), (op == OP_DIV && rb == 0) ? 0 : W);
        end

        check("expq_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
